ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the 32-bit ALU in the 5-stage MIPS pipeline.
- Captures ALU result, zero flag, store data, destination register and MEM/WB controls.
- Registers branch resolution (taken flag and target) for the PC mux.
- Tracks the multi-cycle multiplier with a busy FSM. Raises a stall interlock when a HI/LO read or a second multiply reaches EX while the multiply is still in flight.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-file index width.
- MUL_CYCLES, 32, multiplier latency in cycles from en_mul to product valid in HiLo (must be >= 2).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_alu_out  in  DATA_W  ALU dataOut.
- ex_zero  in  1  ALU zero, already inverted by the ALU for BNE.
- ex_store_data  in  DATA_W  rt value for sw.
- ex_wr_reg  in  REG_W  destination register index.
- ex_branch_target  in  DATA_W  PC+4+(imm<<2).
- ex_valid  in  1  EX holds a real instruction.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  in  1 each  decoded controls.
- ex_en_mul  in  1  EX instruction is mult (same signal driven to the ALU).
- ex_hilo_read  in  1  EX instruction is mfhi/mflo.
- flush  in  1  squash the instruction being captured.
- mem_stall  in  1  MEM stage cannot accept; hold contents.
- mem_alu_out, mem_store_data  out  DATA_W  registered copies.
- mem_wr_reg  out  REG_W  registered copy.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1  registered controls.
- mem_valid  out  1  register holds a real instruction.
- mem_pc_src  out  1  branch taken (registered ex_branch & ex_zero & ex_valid).
- mem_branch_target  out  DATA_W  registered target.
- stall_req  out  1  combinational interlock to the hazard unit; freezes IF/ID/EX.
- mul_busy  out  1  multiplier in flight.
- hilo_ready  out  1  one-cycle pulse when the product is latched in HiLo.

Behaviour:
- Reset (rst=0, async): all mem_* outputs 0, mem_valid=0, mem_pc_src=0, FSM=IDLE, counter=0, mul_busy=0, hilo_ready=0. stall_req=0 follows from IDLE.
- Capture priority per rising edge, highest first:
  1. flush: bubble. All controls, mem_valid and mem_pc_src go to 0; data fields are don't-care and are zeroed.
  2. mem_stall: hold every mem_* register.
  3. stall_req: insert a bubble (same as flush). The EX instruction stays in EX.
  4. Otherwise: capture all ex_* fields. Controls are ANDed with ex_valid.
- flush and mem_stall together: flush wins, so the register is cleared.
- Multiplier FSM (counter width $clog2(MUL_CYCLES)):
  - IDLE: on ex_en_mul & ex_valid & ~stall_req & ~mem_stall, go to RUN with counter=MUL_CYCLES-2.
  - RUN: mul_busy=1. Counter decrements each cycle regardless of mem_stall. At counter==0, go to DONE.
  - DONE: hilo_ready=1 and mul_busy=0 for exactly one cycle. Then go to IDLE. If a new multiply is accepted in DONE under the IDLE acceptance condition, go straight to RUN instead.
  - Result: hilo_ready rises exactly MUL_CYCLES cycles after the accepting edge.
- stall_req = (state==RUN) & ex_valid & (ex_hilo_read | ex_en_mul). It is 0 in IDLE and DONE, so mfhi issued in the DONE cycle proceeds.
- The multiply instruction itself passes into MEM as a normal instruction with reg_write=0 from decode; the block does not force it.
- Reset mid-RUN: FSM goes to IDLE immediately, with no hilo_ready pulse.
- Branch: mem_pc_src is valid only for the captured instruction. The hazard unit owns flushing the wrong path; this block never self-flushes.

Test Plan:
- Reset then plain add: ex_alu_out=0x0000_0007, ex_wr_reg=5, reg_write=1, valid=1 -> next edge mem_alu_out=7, mem_wr_reg=5, mem_reg_write=1, mem_valid=1. Assert rst=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- beq taken: ex_branch=1, ex_zero=1, target=0x0000_0040 -> mem_pc_src=1, mem_branch_target=0x40. Same with ex_zero=0 -> mem_pc_src=0.
- mult then mfhi back-to-back (MUL_CYCLES=32): mul_busy high 31 cycles, stall_req high while mfhi sits in EX, bubbles (mem_valid=0) inserted. hilo_ready pulses at cycle 32; mfhi captured on the following edge.
- mem_stall=1 for 3 cycles with a valid lw in the register -> outputs held constant. Multiplier counter keeps counting during the stall.
- flush=1 together with mem_stall=1 and a valid sw arriving -> mem_valid=0, mem_mem_write=0.
- Reset asserted at RUN counter=10 -> mul_busy=0 immediately, no hilo_ready pulse. A subsequent mult is accepted and completes in exactly 32 cycles.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 5-stage MIPS pipeline.
// Captures the ALU result and MEM/WB controls, registers branch resolution
// for the PC mux, and tracks the multi-cycle multiplier. While a multiply is
// in flight it raises an interlock against HI/LO reads and back-to-back mults.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_wr_reg,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_branch,
  input  logic              ex_en_mul,
  input  logic              ex_hilo_read,
  input  logic              flush,
  input  logic              mem_stall,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_wr_reg,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_valid,
  output logic              mem_pc_src,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic              stall_req,
  output logic              mul_busy,
  output logic              hilo_ready
);

  localparam int               CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } mul_state_t;

  // Everything the MEM stage sees, held as one register so a bubble is '0.
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  wr_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              valid;
    logic              pc_src;
    logic [DATA_W-1:0] branch_target;
  } stage_t;

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_t           stage_q, stage_ex;
  logic             mul_accept;

  // Interlock: HI/LO is not valid yet, and the multiplier cannot take a second op.
  assign stall_req  = (state_q == S_RUN) & ex_valid & (ex_hilo_read | ex_en_mul);
  assign mul_busy   = (state_q == S_RUN);
  assign hilo_ready = (state_q == S_DONE);
  assign mul_accept = ex_en_mul & ex_valid & ~stall_req & ~mem_stall;

  // Multiplier FSM state and latency counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier next-state: the counter runs even while MEM is stalled.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mul_accept) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (mul_accept) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Incoming instruction with every control qualified by ex_valid.
  always_comb begin
    stage_ex               = '0;
    stage_ex.alu_out       = ex_alu_out;
    stage_ex.store_data    = ex_store_data;
    stage_ex.wr_reg        = ex_wr_reg;
    stage_ex.reg_write     = ex_reg_write & ex_valid;
    stage_ex.mem_read      = ex_mem_read & ex_valid;
    stage_ex.mem_write     = ex_mem_write & ex_valid;
    stage_ex.mem_to_reg    = ex_mem_to_reg & ex_valid;
    stage_ex.valid         = ex_valid;
    stage_ex.pc_src        = ex_branch & ex_zero & ex_valid;
    stage_ex.branch_target = ex_branch_target;
  end

  // Pipeline register: flush beats hold, hold beats interlock bubble, else capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (mem_stall) begin
      stage_q <= stage_q;
    end else if (stall_req) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_ex;
    end
  end

  assign mem_alu_out       = stage_q.alu_out;
  assign mem_store_data    = stage_q.store_data;
  assign mem_wr_reg        = stage_q.wr_reg;
  assign mem_reg_write     = stage_q.reg_write;
  assign mem_mem_read      = stage_q.mem_read;
  assign mem_mem_write     = stage_q.mem_write;
  assign mem_mem_to_reg    = stage_q.mem_to_reg;
  assign mem_valid         = stage_q.valid;
  assign mem_pc_src        = stage_q.pc_src;
  assign mem_branch_target = stage_q.branch_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vectors, expected MEM-stage payloads
// queued at issue time and compared by an independent monitor on capture.
`timescale 1ns/1ps
module tb_ex_mem_stage;

  localparam int DATA_W     = 32;
  localparam int REG_W      = 5;
  localparam int MUL_CYCLES = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] ex_alu_out, ex_store_data, ex_branch_target;
  logic              ex_zero, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              ex_mem_to_reg, ex_branch, ex_en_mul, ex_hilo_read;
  logic [REG_W-1:0]  ex_wr_reg;
  logic              flush, mem_stall;
  logic [DATA_W-1:0] mem_alu_out, mem_store_data, mem_branch_target;
  logic [REG_W-1:0]  mem_wr_reg;
  logic              mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic              mem_valid, mem_pc_src, stall_req, mul_busy, hilo_ready;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        pc_src;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp, mon_got;
  logic pend = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_store_data(ex_store_data),
    .ex_wr_reg(ex_wr_reg), .ex_branch_target(ex_branch_target), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_en_mul(ex_en_mul),
    .ex_hilo_read(ex_hilo_read), .flush(flush), .mem_stall(mem_stall),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_wr_reg(mem_wr_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_valid(mem_valid), .mem_pc_src(mem_pc_src), .mem_branch_target(mem_branch_target),
    .stall_req(stall_req), .mul_busy(mul_busy), .hilo_ready(hilo_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_alu_out = '0; ex_store_data = '0; ex_branch_target = '0; ex_wr_reg = '0;
    ex_zero = 0; ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; ex_branch = 0; ex_en_mul = 0; ex_hilo_read = 0;
    flush = 0; mem_stall = 0;
  endtask

  // Multiplier timeline: n = edges counted from the accepting edge (n=1).
  task automatic check_mul(input string tag, input int n);
    check({tag, "_mul_busy"}, mul_busy, (n <= MUL_CYCLES - 1));
    check({tag, "_hilo_ready"}, hilo_ready, (n == MUL_CYCLES));
  endtask

  // Monitor: on each capture of a valid instruction, pop and compare the payload.
  always @(negedge clk) begin
    if (pend) begin
      check("mon_valid", mem_valid, 1'b1);
      check("sb_nonempty", (sb.size() != 0), 1'b1);
      if (mem_valid && sb.size() != 0) begin
        mon_exp = sb.pop_front();
        mon_got = {mem_alu_out, mem_store_data, mem_wr_reg, mem_reg_write, mem_mem_read,
                   mem_mem_write, mem_mem_to_reg, mem_pc_src, mem_branch_target};
        check("sb_payload", mon_got, mon_exp);
      end
    end
    pend = rst && ex_valid && !flush && !mem_stall && !stall_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #3;
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_alu_out", mem_alu_out, 32'h0);
    check("rst_pc_src", mem_pc_src, 1'b0);
    check("rst_mul_busy", mul_busy, 1'b0);
    check("rst_hilo_ready", hilo_ready, 1'b0);
    check("rst_stall_req", stall_req, 1'b0);
    tick();
    rst = 1'b1;

    // Plain add.
    ex_valid = 1; ex_alu_out = 32'h0000_0007; ex_wr_reg = 5; ex_reg_write = 1;
    sb.push_back('{32'h7, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    check("add_alu_out", mem_alu_out, 32'h7);
    check("add_wr_reg", mem_wr_reg, 5'd5);
    check("add_reg_write", mem_reg_write, 1'b1);
    check("add_valid", mem_valid, 1'b1);
    idle_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_alu_out", mem_alu_out, 32'h0);
    check("arst_wr_reg", mem_wr_reg, 5'd0);
    check("arst_reg_write", mem_reg_write, 1'b0);
    check("arst_valid", mem_valid, 1'b0);
    tick();
    rst = 1'b1;

    // beq taken, then not taken, then an invalid branch.
    ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_branch_target = 32'h0000_0040;
    sb.push_back('{32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40});
    tick();
    check("beq_taken_pc_src", mem_pc_src, 1'b1);
    check("beq_taken_target", mem_branch_target, 32'h40);
    ex_zero = 0; ex_alu_out = 32'h3;
    sb.push_back('{32'h3, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40});
    tick();
    check("beq_nt_pc_src", mem_pc_src, 1'b0);
    ex_zero = 1; ex_valid = 0;
    tick();
    check("beq_inv_valid", mem_valid, 1'b0);
    check("beq_inv_pc_src", mem_pc_src, 1'b0);
    idle_inputs();

    // mult followed immediately by mfhi.
    ex_valid = 1; ex_en_mul = 1; ex_alu_out = 32'h1234;
    sb.push_back('{32'h1234, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    ex_en_mul = 0; ex_hilo_read = 1; ex_reg_write = 1; ex_wr_reg = 8; ex_alu_out = 32'hABCD;
    sb.push_back('{32'hABCD, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    #1;
    check_mul("mfhi", 1);
    check("mfhi_stall_1", stall_req, 1'b1);
    for (int n = 2; n <= MUL_CYCLES + 1; n++) begin
      tick();
      check_mul("mfhi", n);
      check("mfhi_stall_req", stall_req, (n <= MUL_CYCLES - 1));
      check("mfhi_mem_valid", mem_valid, (n == MUL_CYCLES + 1));
    end
    idle_inputs();

    // mem_stall holding a lw while the multiplier keeps counting.
    ex_valid = 1; ex_en_mul = 1; ex_alu_out = 32'h55;
    sb.push_back('{32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    ex_en_mul = 0; ex_alu_out = 32'h100; ex_wr_reg = 9;
    ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1;
    sb.push_back('{32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
    tick();
    idle_inputs();
    mem_stall = 1; ex_valid = 1; ex_alu_out = 32'h104; ex_store_data = 32'hDEAD_BEEF;
    ex_mem_write = 1;
    sb.push_back('{32'h104, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    for (int n = 3; n <= 5; n++) begin
      tick();
      check("hold_alu_out", mem_alu_out, 32'h100);
      check("hold_wr_reg", mem_wr_reg, 5'd9);
      check("hold_mem_read", mem_mem_read, 1'b1);
      check("hold_mem_write", mem_mem_write, 1'b0);
      check_mul("hold", n);
    end
    mem_stall = 0;
    tick();
    check("sw_mem_write", mem_mem_write, 1'b1);
    check_mul("hold", 6);
    idle_inputs();
    for (int n = 7; n <= MUL_CYCLES + 1; n++) begin
      tick();
      check_mul("hold", n);
    end

    // flush together with mem_stall while a sw arrives.
    ex_valid = 1; ex_alu_out = 32'h200; ex_wr_reg = 10;
    ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1;
    sb.push_back('{32'h200, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
    tick();
    idle_inputs();
    flush = 1; mem_stall = 1; ex_valid = 1; ex_alu_out = 32'h204; ex_mem_write = 1;
    tick();
    check("flush_valid", mem_valid, 1'b0);
    check("flush_mem_write", mem_mem_write, 1'b0);
    check("flush_reg_write", mem_reg_write, 1'b0);
    check("flush_alu_out", mem_alu_out, 32'h0);
    idle_inputs();

    // Reset while the multiplier is at counter 10, then a clean mult.
    ex_valid = 1; ex_en_mul = 1; ex_alu_out = 32'h77;
    sb.push_back('{32'h77, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    idle_inputs();
    for (int n = 2; n <= MUL_CYCLES - 11; n++) begin
      tick();
      check_mul("prerst", n);
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_mul_busy", mul_busy, 1'b0);
    check("midrst_hilo_ready", hilo_ready, 1'b0);
    check("midrst_mem_valid", mem_valid, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("postrst_hilo_ready", hilo_ready, 1'b0);
      check("postrst_mul_busy", mul_busy, 1'b0);
    end
    ex_valid = 1; ex_en_mul = 1; ex_alu_out = 32'h99;
    sb.push_back('{32'h99, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    tick();
    idle_inputs();
    check_mul("remul", 1);
    for (int n = 2; n <= MUL_CYCLES + 1; n++) begin
      tick();
      check_mul("remul", n);
    end

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
